// File: rtl/lifo_frame_reverser.sv
// Frame reverser in front of a fixed-latency LIFO stack.
// Ports: s_* input stream, m_* output stream, lifo_* stack strobes/data,
//        frame_err oversize pulse, busy while a frame is held or draining.
module lifo_frame_reverser #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int POP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [WIDTH-1:0] lifo_din,
  input  logic [WIDTH-1:0] lifo_dout,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BUF = POP_LAT + 2;
  localparam int PW  = $clog2(BUF);
  localparam int OW  = $clog2(BUF + 1);
  localparam int UW  = OW + 1;

  typedef enum logic [1:0] {
    FILL,
    DISCARD,
    DRAIN
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [POP_LAT-1:0] fl_v;
  logic [POP_LAT-1:0] fl_last;
  logic [WIDTH-1:0]   mem [BUF];
  logic [BUF-1:0]     mem_last;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [OW-1:0]      occ;
  logic [OW-1:0]      inflight;
  logic [UW-1:0]      used;
  logic               accept;
  logic               sample;
  logic               deq;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < POP_LAT; i++)
      inflight = inflight + OW'(fl_v[i]);
  end

  // Credits cover words still inside the stack
  // pipeline plus words parked in the buffer.
  assign used = UW'(inflight) + UW'(occ);

  // Combinational strobes are gated by rst so the
  // reset cycle itself shows idle outputs.
  assign s_ready = !rst && (state != DRAIN);
  assign accept  = s_valid && s_ready;

  assign lifo_push = accept && (state == FILL)
                  && (cnt < CW'(DEPTH));
  assign frame_err = accept && (state == FILL)
                  && (cnt == CW'(DEPTH));
  assign lifo_din  = lifo_push ? s_data : '0;

  assign lifo_pop = !rst && (state == DRAIN)
                 && (cnt != '0)
                 && (used < UW'(BUF));

  assign sample  = fl_v[POP_LAT-1];
  assign m_valid = !rst && (occ != '0);
  assign m_data  = m_valid ? mem[rptr] : '0;
  assign m_last  = m_valid && mem_last[rptr];
  assign deq     = m_valid && m_ready;
  assign busy    = !rst
                && ((state != FILL) || (cnt != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      fl_v     <= '0;
      fl_last  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      mem_last <= '0;
      for (int i = 0; i < BUF; i++)
        mem[i] <= '0;
    end else begin
      fl_v    <= (fl_v << 1)
               | POP_LAT'(lifo_pop);
      // Final pop of the frame carries the first
      // input word, which closes the output frame.
      fl_last <= (fl_last << 1)
               | POP_LAT'(lifo_pop
                          && (cnt == CW'(1)));

      if (sample) begin
        mem[wptr]      <= lifo_dout;
        mem_last[wptr] <= fl_last[POP_LAT-1];
        wptr           <= inc(wptr);
      end
      if (deq)
        rptr <= inc(rptr);

      unique case ({sample, deq})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase

      if (lifo_push)
        cnt <= cnt + CW'(1);
      else if (lifo_pop)
        cnt <= cnt - CW'(1);

      unique case (state)
        FILL: begin
          if (accept) begin
            if (s_last)
              state <= DRAIN;
            else if (cnt == CW'(DEPTH))
              state <= DISCARD;
          end
        end
        DISCARD: begin
          if (accept && s_last)
            state <= DRAIN;
        end
        DRAIN: begin
          // The tagged word is the final pop, so the
          // stack and pipeline are empty once it leaves.
          if (deq && m_last)
            state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Bench for lifo_frame_reverser with a behavioural stack model
// and a queue-based scoreboard of reversed frames.
module tb_lifo_frame_reverser;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int POP_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             lifo_push;
  logic             lifo_pop;
  logic [WIDTH-1:0] lifo_din;
  logic [WIDTH-1:0] lifo_dout;
  logic             frame_err;
  logic             busy;

  always #5 clk = ~clk;

  lifo_frame_reverser #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .POP_LAT(POP_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .lifo_push(lifo_push),
    .lifo_pop(lifo_pop),
    .lifo_din(lifo_din),
    .lifo_dout(lifo_dout),
    .frame_err(frame_err),
    .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  exp_t             exp_q[$];
  int               len_q[$];
  logic [WIDTH-1:0] frame_q[$];
  int               checks = 0;
  int               errors = 0;
  bit               rnd_mode = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Stack: push stores on top, pop presents old top
  // POP_LAT cycles later; shares rst with the DUT.
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] dpipe [POP_LAT];
  int               sp = 0;

  assign lifo_dout = dpipe[POP_LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      for (int i = 0; i < POP_LAT; i++)
        dpipe[i] <= '0;
    end else begin
      if (lifo_push && sp < DEPTH) begin
        stk[sp] <= lifo_din;
        sp      <= sp + 1;
      end else if (lifo_pop && sp > 0) begin
        dpipe[0] <= stk[sp-1];
        sp       <= sp - 1;
      end
      for (int i = 1; i < POP_LAT; i++)
        dpipe[i] <= dpipe[i-1];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_mode ? 1'($urandom_range(0, 1))
                         : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  int               outst = 0;
  int               fpops = 0;
  bit               hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic             hold_l;
  bit               after_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      outst      = 0;
      fpops      = 0;
      hold_v     = 1'b0;
      after_last = 1'b0;
    end else begin
      chk("push_pop_excl", 32'(lifo_push && lifo_pop), 0);
      chk("no_overflow", 32'(lifo_push && sp >= DEPTH), 0);
      chk("no_underflow", 32'(lifo_pop && sp == 0), 0);
      if (after_last) begin
        chk("busy_after_last", 32'(busy), 0);
        chk("ready_after_last", 32'(s_ready), 1);
        after_last = 1'b0;
      end
      if (hold_v) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(hold_d));
        chk("stall_last", 32'(m_last), 32'(hold_l));
      end
      if (lifo_pop) begin
        outst++;
        fpops++;
      end
      chk("credit", 32'(outst <= POP_LAT + 2), 1);
      if (m_valid && m_ready) begin
        outst--;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(m_data), 32'hdead_beef);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(m_data), 32'(e.d));
          chk("out_last", 32'(m_last), 32'(e.l));
          if (m_last) begin
            if (len_q.size() > 0)
              chk("pop_count", 32'(fpops), 32'(len_q.pop_front()));
            chk("stack_empty", 32'(sp), 0);
            after_last = 1'b1;
            fpops      = 0;
          end
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] d,
                           input bit l,
                           input bit exp_push,
                           input bit exp_err);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        chk("push", 32'(lifo_push), 32'(exp_push));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        if (exp_push)
          chk("din", 32'(lifo_din), 32'(d));
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 300) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Reference: keep the first DEPTH words, emit them
  // newest first, flag the oldest as last.
  task automatic send_frame(input bit gaps);
    int n    = frame_q.size();
    int kept = (n < DEPTH) ? n : DEPTH;
    for (int i = kept - 1; i >= 0; i--)
      exp_q.push_back('{d: frame_q[i], l: (i == 0)});
    len_q.push_back(kept);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(frame_q[i], i == n - 1,
                i < DEPTH, i == DEPTH);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_push", 32'(lifo_push), 0);
    chk("rst_pop", 32'(lifo_pop), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(s_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_mdata", 32'(m_data), 0);
    chk("post_rst_mlast", 32'(m_last), 0);
    chk("post_rst_din", 32'(lifo_din), 0);
    @(posedge clk);
    #1;

    frame_q = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    send_frame(1'b0);
    k = 1;
    forever begin
      @(negedge clk);
      if (k == 1)
        chk("first_pop", 32'(lifo_pop), 1);
      if (m_valid || k > 20)
        break;
      @(posedge clk);
      #1;
      k++;
    end
    chk("first_valid_lat", 32'(k), 32'(2 + POP_LAT));
    wait_drain();

    frame_q = '{16'h1234};
    send_frame(1'b0);
    wait_drain();

    frame_q.delete();
    for (int i = 0; i < 16; i++)
      frame_q.push_back(16'(i));
    send_frame(1'b0);
    wait_drain();

    frame_q.delete();
    for (int i = 0; i < 18; i++)
      frame_q.push_back(16'h0100 + 16'(i));
    send_frame(1'b0);
    wait_drain();

    rnd_mode = 1'b1;
    frame_q.delete();
    for (int i = 0; i < 8; i++)
      frame_q.push_back(16'($urandom));
    send_frame(1'b1);
    wait_drain();
    rnd_mode = 1'b0;

    frame_q.delete();
    for (int i = 0; i < 6; i++)
      frame_q.push_back(16'h0600 + 16'(i));
    send_frame(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    len_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_old_output", 32'(m_valid), 0);
    end
    @(posedge clk);
    #1;
    frame_q = '{16'hBEEF, 16'hCAFE};
    send_frame(1'b0);
    wait_drain();

    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 20);
      rnd_mode = 1'($urandom_range(0, 1));
      frame_q.delete();
      for (int i = 0; i < n; i++)
        frame_q.push_back(16'($urandom));
      send_frame(1'b1);
    end
    wait_drain();
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
